// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared widths, op encodings and FSM states for the stack sequencer
package stack_ctrl_pkg;

   localparam int DW    = 16;
   localparam int DEPTH = 32;
   localparam int SPW   = $clog2(DEPTH) + 1;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_PUSH = 3'd1,
      OP_POP  = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4,
      OP_CLR  = 3'd5
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE
   } state_t;

   // Codes 6 and 7 are reserved and behave exactly like NOP.
   function automatic logic is_nop(input logic [2:0] op);
      return (op == OP_NOP) || (op > OP_CLR);
   endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - request/response handshake between control unit and stack sequencer
interface stack_ctrl_if;
   import stack_ctrl_pkg::*;

   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic [DW-1:0] req_data;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          pc_load;

   modport master (
      output req_valid, req_op, req_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err, pc_load
   );

   modport slave (
      input  req_valid, req_op, req_data,
      output req_ready, rsp_valid, rsp_data, rsp_err, pc_load
   );

endinterface

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - sequences PUSH/POP/CALL/RET/CLR onto the 32x16 LIFO and tracks its depth
module stack_ctrl
   import stack_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   stack_ctrl_if.slave    bus,
   output logic [DW-1:0]  stk_din,
   output logic           stk_en,
   output logic           stk_rw,
   output logic           stk_rst,
   input  logic [DW-1:0]  stk_dout,
   output logic [SPW-1:0] depth,
   output logic           full,
   output logic           empty,
   output logic           err_ovf,
   output logic           err_unf
);

   state_t        state;
   logic [2:0]    op_q;
   logic [DW-1:0] data_q;
   logic          is_wr;
   logic          is_rd;
   logic          is_clr;

   assign is_wr  = (op_q == OP_PUSH) || (op_q == OP_CALL);
   assign is_rd  = (op_q == OP_POP)  || (op_q == OP_RET);
   assign is_clr = (op_q == OP_CLR);

   assign full          = (depth == SPW'(DEPTH));
   assign empty         = (depth == '0);
   assign bus.req_ready = (state == IDLE);

   // Stack pins are decoded from registered state; rst drives the stack's own clear directly.
   always_comb begin
      stk_en  = 1'b0;
      stk_rw  = 1'b0;
      stk_rst = 1'b0;
      stk_din = '0;
      if (rst) begin
         stk_en  = 1'b1;
         stk_rst = 1'b1;
      end else if (state == ISSUE) begin
         if (is_wr && !full) begin
            stk_en  = 1'b1;
            stk_rw  = 1'b1;
            stk_din = (op_q == OP_CALL) ? data_q + 1'b1 : data_q;
         end else if (is_rd && !empty) begin
            stk_en = 1'b1;
         end else if (is_clr) begin
            stk_en  = 1'b1;
            stk_rst = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         op_q          <= OP_NOP;
         data_q        <= '0;
         depth         <= '0;
         err_ovf       <= 1'b0;
         err_unf       <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_data  <= '0;
         bus.pc_load   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.pc_load   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q   <= bus.req_op;
                  data_q <= bus.req_data;
                  if (!is_nop(bus.req_op))
                     state <= ISSUE;
               end
            end
            ISSUE: begin
               state <= IDLE;
               if (is_wr) begin
                  if (full) err_ovf <= 1'b1;
                  else      depth   <= depth + 1'b1;
               end else if (is_rd) begin
                  if (empty) begin
                     err_unf       <= 1'b1;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_data  <= '0;
                  end else begin
                     depth <= depth - 1'b1;
                     state <= CAPTURE;
                  end
               end else if (is_clr) begin
                  depth   <= '0;
                  err_ovf <= 1'b0;
                  err_unf <= 1'b0;
               end
            end
            CAPTURE: begin
               bus.rsp_data  <= stk_dout;
               bus.rsp_valid <= 1'b1;
               bus.pc_load   <= (op_q == OP_RET);
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed bench for stack_ctrl against a behavioural 32x16 LIFO
module tb_stack_ctrl;
   import stack_ctrl_pkg::*;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [DW-1:0]  stk_din;
   logic           stk_en, stk_rw, stk_rst;
   logic [DW-1:0]  stk_dout = '0;
   logic [SPW-1:0] depth;
   logic           full, empty, err_ovf, err_unf;

   logic [5:0]     sp;
   logic [15:0]    mem [32];

   int errors = 0;
   int checks = 0;

   stack_ctrl_if bus ();

   stack_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .stk_din  (stk_din),
      .stk_en   (stk_en),
      .stk_rw   (stk_rw),
      .stk_rst  (stk_rst),
      .stk_dout (stk_dout),
      .depth    (depth),
      .full     (full),
      .empty    (empty),
      .err_ovf  (err_ovf),
      .err_unf  (err_unf)
   );

   always #5 clk = ~clk;

   // Stack: rst clears the pointer, write stores at sp, read presents mem[sp-1] next cycle.
   always @(posedge clk) begin
      if (stk_en) begin
         if (stk_rst) begin
            sp <= 6'd0;
         end else if (stk_rw) begin
            mem[sp[4:0]] <= stk_din;
            sp           <= sp + 6'd1;
         end else begin
            stk_dout <= mem[5'(sp - 6'd1)];
            sp       <= sp - 6'd1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns one cycle after the accept edge, i.e. with the FSM in ISSUE.
   task automatic send(input logic [2:0] op, input logic [15:0] d);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = d;
      for (int i = 0; i < 10 && !bus.req_ready; i++) step();
      check("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic push(input logic [15:0] d, input logic [5:0] dep_after);
      send(OP_PUSH, d);
      check("push_stk_en", {31'd0, stk_en}, 32'd1);
      check("push_stk_din", {16'd0, stk_din}, {16'd0, d});
      step();
      check("push_depth", {26'd0, depth}, {26'd0, dep_after});
   endtask

   task automatic pop(input logic [15:0] exp, input logic [5:0] dep_after);
      send(OP_POP, 16'd0);
      check("pop_stk_en", {31'd0, stk_en}, 32'd1);
      check("pop_stk_rw", {31'd0, stk_rw}, 32'd0);
      step();
      check("pop_capture_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      step();
      check("pop_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("pop_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      check("pop_rsp_data", {16'd0, bus.rsp_data}, {16'd0, exp});
      check("pop_depth", {26'd0, depth}, {26'd0, dep_after});
      check("pop_depth_vs_stack", {26'd0, depth}, {26'd0, sp});
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_data  = 16'd0;

      // Reset
      #1;
      check("rst_stk_rst", {31'd0, stk_rst}, 32'd1);
      check("rst_stk_en", {31'd0, stk_en}, 32'd1);
      step();
      step();
      check("rst_depth", {26'd0, depth}, 32'd0);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.pc_load}, 32'd0);
      check("rst_err", {30'd0, err_ovf, err_unf}, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_stk_en", {31'd0, stk_en}, 32'd0);

      // Basic push/pop
      push(16'h1111, 6'd1);
      push(16'h2222, 6'd2);
      pop(16'h2222, 6'd1);
      step();
      check("rsp_valid_one_pulse", {31'd0, bus.rsp_valid}, 32'd0);
      check("rsp_data_held", {16'd0, bus.rsp_data}, 32'h2222);
      pop(16'h1111, 6'd0);

      // NOP and reserved codes stay in IDLE
      send(3'd7, 16'h0);
      check("nop_ready", {31'd0, bus.req_ready}, 32'd1);
      check("nop_stk_en", {31'd0, stk_en}, 32'd0);

      // CALL / RET
      send(OP_CALL, 16'h00FF);
      check("call_stk_din", {16'd0, stk_din}, 32'h0100);
      check("call_stk_rw", {31'd0, stk_rw}, 32'd1);
      step();
      send(OP_RET, 16'h0);
      step();
      step();
      check("ret_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("ret_pc_load", {31'd0, bus.pc_load}, 32'd1);
      check("ret_rsp_data", {16'd0, bus.rsp_data}, 32'h0100);
      step();
      check("pc_load_one_pulse", {31'd0, bus.pc_load}, 32'd0);
      send(OP_CALL, 16'hFFFF);
      check("call_wrap_din", {16'd0, stk_din}, 32'h0000);
      step();
      pop(16'h0000, 6'd0);
      check("pop_no_pc_load", {31'd0, bus.pc_load}, 32'd0);

      // Fill to full, overflow, drain
      for (int i = 0; i < 32; i++) push(16'(i * 37 + 5), 6'(i + 1));
      check("full_flag", {31'd0, full}, 32'd1);
      send(OP_PUSH, 16'hBEEF);
      check("ovf_stk_en", {31'd0, stk_en}, 32'd0);
      step();
      check("ovf_err", {31'd0, err_ovf}, 32'd1);
      check("ovf_depth", {26'd0, depth}, 32'd32);
      for (int i = 31; i >= 0; i--) pop(16'(i * 37 + 5), 6'(i));
      check("drained_empty", {31'd0, empty}, 32'd1);
      check("ovf_sticky", {31'd0, err_ovf}, 32'd1);

      // Underflow then CLR
      send(OP_POP, 16'h0);
      check("unf_stk_en", {31'd0, stk_en}, 32'd0);
      step();
      check("unf_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("unf_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
      check("unf_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
      check("unf_err", {31'd0, err_unf}, 32'd1);
      step();
      check("unf_pulse_end", {31'd0, bus.rsp_valid}, 32'd0);
      check("unf_sticky", {31'd0, err_unf}, 32'd1);
      push(16'hAAAA, 6'd1);
      send(OP_CLR, 16'h0);
      check("clr_stk_rst", {30'd0, stk_en, stk_rst}, 32'd3);
      step();
      check("clr_depth", {26'd0, depth}, 32'd0);
      check("clr_errs", {30'd0, err_ovf, err_unf}, 32'd0);
      step();
      check("clr_stack_ptr", {26'd0, sp}, 32'd0);

      // Held req_valid across a busy POP is taken only once
      push(16'h1234, 6'd1);
      push(16'h5678, 6'd2);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_POP;
      bus.req_data  = 16'h0;
      step();
      check("busy_ready_issue", {31'd0, bus.req_ready}, 32'd0);
      step();
      check("busy_ready_capture", {31'd0, bus.req_ready}, 32'd0);
      step();
      bus.req_valid = 1'b0;
      check("held_rsp_data", {16'd0, bus.rsp_data}, 32'h5678);
      step();
      check("held_single_pop", {26'd0, depth}, 32'd1);
      pop(16'h1234, 6'd0);

      // Reset during CAPTURE abandons the response
      push(16'h5555, 6'd1);
      send(OP_POP, 16'h0);
      step();
      rst = 1'b1;
      #1;
      check("rst_mid_stk_rst", {30'd0, stk_en, stk_rst}, 32'd3);
      step();
      check("rst_mid_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_mid_depth", {26'd0, depth}, 32'd0);
      check("rst_mid_idle", {31'd0, bus.req_ready}, 32'd1);
      rst = 1'b0;
      step();
      check("rst_mid_still_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_mid_stack_ptr", {26'd0, sp}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
